branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit_pkg.sv | 23 ++
 rtl/cond_eval.sv | 38 +++
 rtl/branch_unit.sv | 96 +++++++++
 tb/tb_branch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_unit_pkg.sv
// rtl/branch_unit_pkg.sv - shared types and constants for the branch unit
package branch_unit_pkg;

  // Bit positions inside the {N,Z,C,V} flags vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // 2-bit saturating predictor states
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_HS = 4'd2,  COND_LO = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - A64 condition code evaluation against {N,Z,C,V}
module cond_eval
  import branch_unit_pkg::*;
(
  input  logic [3:0] ex_cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition code; AL and NV both mean always
  always_comb begin
    cond_true = 1'b1;
    case (cond_e'(ex_cond))
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_HS: cond_true = c;
      COND_LO: cond_true = !c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = !n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = !v;
      COND_HI: cond_true = c && !z;
      COND_LS: cond_true = !(c && !z);
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = !z && (n == v);
      COND_LE: cond_true = !(!z && (n == v));
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch resolution, 2-bit BHT predictor, flags and statistics
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int PC_W      = 64,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_uncond,
  input  logic              ex_cbz,
  input  logic              ex_cbnz,
  input  logic              ex_bcond,
  input  logic [3:0]        ex_cond,
  input  logic              ex_is_zero,
  input  logic              ex_pred_taken,
  input  logic              fwd_set_flags,
  input  logic [3:0]        fwd_flags,
  output logic              take_branch,
  output logic              mispredict,
  output logic [3:0]        flags,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [3:0]       eff_flags;
  logic             cond_true;
  logic             is_cond;
  logic             is_branch;

  // Word-aligned instructions: skip the two low PC bits when indexing
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  logic unused_pc;
  assign unused_pc = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0], ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is not visible yet
  assign if_pred_taken = bht[if_idx][1];

  // A flag-setting instruction ahead of the branch wins over the register
  assign eff_flags = fwd_set_flags ? fwd_flags : flags;

  cond_eval u_cond_eval (
    .ex_cond   (ex_cond),
    .flags     (eff_flags),
    .cond_true (cond_true)
  );

  assign is_cond     = ex_valid && (ex_cbz || ex_cbnz || ex_bcond);
  assign is_branch   = is_cond || (ex_valid && ex_uncond);
  assign take_branch = ex_valid && (ex_uncond || (ex_cbz && ex_is_zero) ||
                                    (ex_cbnz && !ex_is_zero) || (ex_bcond && cond_true));
  assign mispredict  = is_branch && (take_branch ^ ex_pred_taken);

  // Saturating predictor training on conditional branches only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_WNT;
    end else if (is_cond) begin
      if (take_branch) begin
        if (bht[ex_idx] != CTR_ST) bht[ex_idx] <= bht[ex_idx] + 2'd1;
      end else begin
        if (bht[ex_idx] != CTR_SNT) bht[ex_idx] <= bht[ex_idx] - 2'd1;
      end
    end
  end

  // Architectural flags follow any flag write, valid branch or not
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           flags <= 4'b0000;
    else if (fwd_set_flags) flags <= fwd_flags;
  end

  // Statistics counters that stick at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (is_branch && (branch_cnt != '1))   branch_cnt  <= branch_cnt + STAT_W'(1);
      if (mispredict && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - self-checking bench for branch_unit
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] if_pc, ex_pc;
  logic        ex_valid, ex_uncond, ex_cbz, ex_cbnz, ex_bcond, ex_is_zero, ex_pred_taken;
  logic [3:0]  ex_cond, fwd_flags;
  logic        fwd_set_flags;

  logic        if_pred_taken, take_branch, mispredict;
  logic [3:0]  flags;
  logic [15:0] branch_cnt, mispred_cnt;

  logic        s_if_pred, s_take, s_mis;
  logic [3:0]  s_flags;
  logic [1:0]  s_bcnt, s_mcnt;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk(clk), .reset_n(reset_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_uncond(ex_uncond), .ex_cbz(ex_cbz),
    .ex_cbnz(ex_cbnz), .ex_bcond(ex_bcond), .ex_cond(ex_cond), .ex_is_zero(ex_is_zero),
    .ex_pred_taken(ex_pred_taken), .fwd_set_flags(fwd_set_flags), .fwd_flags(fwd_flags),
    .take_branch(take_branch), .mispredict(mispredict), .flags(flags),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_unit #(.STAT_W(2)) dut_small (
    .clk(clk), .reset_n(reset_n), .if_pc(if_pc), .if_pred_taken(s_if_pred),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_uncond(ex_uncond), .ex_cbz(ex_cbz),
    .ex_cbnz(ex_cbnz), .ex_bcond(ex_bcond), .ex_cond(ex_cond), .ex_is_zero(ex_is_zero),
    .ex_pred_taken(ex_pred_taken), .fwd_set_flags(fwd_set_flags), .fwd_flags(fwd_flags),
    .take_branch(s_take), .mispredict(s_mis), .flags(s_flags),
    .branch_cnt(s_bcnt), .mispred_cnt(s_mcnt)
  );

  typedef struct {
    logic       valid, uncond, cbz, cbnz, bcond;
    logic [3:0] cond;
    logic       is_zero, pred;
    logic [3:0] fflags;
    logic       exp_take, exp_mis;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference A64 evaluation: base test from cond[3:1], inverted by cond[0]
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c & ~z;
      3'd5: r = ~(n ^ v);
      3'd6: r = ~(n ^ v) & ~z;
      default: r = 1'b1;
    endcase
    if (cc[0] && cc[3:1] != 3'd7) r = ~r;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_uncond = 0; ex_cbz = 0; ex_cbnz = 0; ex_bcond = 0;
    ex_cond = 4'd0; ex_is_zero = 0; ex_pred_taken = 0; ex_pc = '0;
    fwd_set_flags = 0; fwd_flags = 4'd0;
  endtask

  task automatic do_reset();
    clear_ex();
    reset_n = 0;
    step(); step();
    reset_n = 1;
  endtask

  task automatic cbz(input logic [63:0] pc, input logic iz, input logic pred);
    ex_valid = 1; ex_cbz = 1; ex_pc = pc; ex_is_zero = iz; ex_pred_taken = pred;
  endtask

  initial begin
    //               valid unc cbz cbnz bc cond  iz pred flags   take mis
    vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,4'b0000,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,4'b0000,1'b1,1'b1};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b1,4'b0000,1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,4'd0, 1'b0,1'b1,4'b0000,1'b0,1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,4'd0, 1'b0,1'b1,4'b0000,1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,4'd0, 1'b1,1'b0,4'b0000,1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,4'd0, 1'b0,1'b0,4'b0100,1'b1,1'b1};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,4'd12,1'b0,1'b1,4'b0000,1'b1,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,4'd12,1'b0,1'b1,4'b1000,1'b0,1'b1};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,4'd8, 1'b0,1'b0,4'b0010,1'b1,1'b1};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,4'd8, 1'b0,1'b0,4'b0110,1'b0,1'b0};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b1,4'b0000,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1,4'd15,1'b0,1'b0,4'b0000,1'b1,1'b1};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1,4'd14,1'b0,1'b1,4'b0000,1'b0,1'b0};

    // Reset state
    if_pc = 64'h1234_5678_9abc_def0;
    clear_ex();
    reset_n = 0;
    #3;
    check("rst_if_pred", if_pred_taken, 0);
    check("rst_flags", flags, 4'b0000);
    check("rst_bcnt", branch_cnt, 0);
    check("rst_mcnt", mispred_cnt, 0);
    step();
    reset_n = 1;
    step();

    // Table of resolve vectors
    for (int i = 0; i < 14; i++) begin
      ex_valid = vecs[i].valid; ex_uncond = vecs[i].uncond; ex_cbz = vecs[i].cbz;
      ex_cbnz = vecs[i].cbnz; ex_bcond = vecs[i].bcond; ex_cond = vecs[i].cond;
      ex_is_zero = vecs[i].is_zero; ex_pred_taken = vecs[i].pred;
      fwd_set_flags = 1; fwd_flags = vecs[i].fflags;
      #1;
      check($sformatf("vec%0d_take", i), take_branch, vecs[i].exp_take);
      check($sformatf("vec%0d_mis", i), mispredict, vecs[i].exp_mis);
      step();
    end

    // B.LT with forwarded flags overriding the register
    do_reset();
    step();
    ex_valid = 1; ex_bcond = 1; ex_cond = 4'd11; ex_pred_taken = 1;
    fwd_set_flags = 1; fwd_flags = 4'b1000;
    #1;
    check("lt_fwd_take", take_branch, 1);
    check("lt_fwd_mis", mispredict, 0);
    step();
    clear_ex();
    #1;
    check("lt_flags_loaded", flags, 4'b1000);
    ex_valid = 1; ex_bcond = 1; ex_cond = 4'd11;
    #1;
    check("lt_reg_take", take_branch, 1);
    clear_ex();
    step();

    // Full condition sweep
    for (int cc = 0; cc < 16; cc++) begin
      for (int f = 0; f < 16; f++) begin
        ex_valid = 1; ex_bcond = 1; ex_cond = 4'(cc);
        fwd_set_flags = 1; fwd_flags = 4'(f);
        #1;
        check($sformatf("sweep_c%0d_f%0h", cc, f), take_branch, ref_cond(4'(cc), 4'(f)));
      end
    end
    clear_ex();

    // Same-cycle lookup and update at index 5
    do_reset();
    step();
    if_pc = 64'h14;
    cbz(64'h14, 1, 0);
    #1;
    check("same_idx_pre", if_pred_taken, 0);
    step();
    clear_ex();
    #1;
    check("same_idx_post", if_pred_taken, 1);

    // Three taken CBZ at 0x40, prediction follows the BHT
    do_reset();
    step();
    if_pc = 64'h40;
    cbz(64'h40, 1, 0);
    #1;
    check("cbz1_take", take_branch, 1);
    check("cbz1_mis", mispredict, 1);
    step();
    cbz(64'h40, 1, 1);
    #1;
    check("cbz2_pred", if_pred_taken, 1);
    check("cbz2_mis", mispredict, 0);
    step();
    cbz(64'h40, 1, 1);
    #1;
    check("cbz3_mis", mispredict, 0);
    step();
    clear_ex();
    #1;
    check("cbz_pred_after", if_pred_taken, 1);
    check("cbz_bcnt", branch_cnt, 3);
    check("cbz_mcnt", mispred_cnt, 1);
    // One not-taken from 11 leaves it predicting taken
    cbz(64'h40, 0, 1);
    #1;
    check("cbz_nt_mis", mispredict, 1);
    step();
    clear_ex();
    #1;
    check("cbz_nt_pred", if_pred_taken, 1);
    check("cbz_nt_bcnt", branch_cnt, 4);
    check("cbz_nt_mcnt", mispred_cnt, 2);
    check("small_bcnt4", s_bcnt, 2'd3);
    ex_valid = 1; ex_uncond = 1; ex_pred_taken = 1;
    step();
    clear_ex();
    #1;
    check("small_bcnt5", s_bcnt, 2'd3);
    check("bcnt5", branch_cnt, 5);

    // Asynchronous reset with an update pending
    cbz(64'h40, 0, 1);
    fwd_set_flags = 1; fwd_flags = 4'b1111;
    #1;
    reset_n = 0;
    #1;
    check("mid_rst_bcnt", branch_cnt, 0);
    check("mid_rst_mcnt", mispred_cnt, 0);
    check("mid_rst_flags", flags, 4'b0000);
    check("mid_rst_small_bcnt", s_bcnt, 2'd0);
    check("mid_rst_pred_entry", if_pc == 64'h40 ? 32'(dut.bht[0]) : 32'hx, 32'h1);
    step();
    clear_ex();
    reset_n = 1;
    #1;
    check("post_rst_flags", flags, 4'b0000);
    check("post_rst_pred", if_pred_taken, 0);
    check("post_rst_bcnt", branch_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
